// File: rtl/fifo_wr_mem_ctrl.sv
// Write-clock half of an asynchronous FIFO: storage array, binary/Gray write pointer,
// full, almost-full, fill level and sticky overflow, all registered in the wclk domain.
module fifo_wr_mem_ctrl #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 3,
    parameter int unsigned AFULL_THRESH = 6,
    parameter bit          RESET_MEM    = 1'b1
) (
    input  logic                  wclk,
    input  logic                  RST,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH:0]   rgray_sync,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  wovf_clr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH:0]   wgray,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  wovf
);

    localparam int unsigned AW    = ADDR_WIDTH;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [AW:0] AFULL_L = (AW + 1)'(AFULL_THRESH);

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = int'(AW) - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wbin;
    logic [AW:0]           r_wgray;
    logic                  r_wfull;
    logic                  r_walmost_full;
    logic [AW:0]           r_wlevel;
    logic                  r_wovf;

    logic                  w_wen;
    logic [AW:0]           w_wbin_next;
    logic [AW:0]           w_wgray_next;
    logic [AW:0]           w_rbin_sync;
    logic [AW:0]           w_level_next;
    logic                  w_full_next;
    logic [AW:0]           w_full_pattern;

    // Next-state pointer, level and full computation from the synchronised read pointer
    always_comb begin
        w_wen          = winc & ~r_wfull;
        w_wbin_next    = r_wbin + {{AW{1'b0}}, w_wen};
        w_wgray_next   = bin2gray(w_wbin_next);
        w_rbin_sync    = gray2bin(rgray_sync);
        w_level_next   = w_wbin_next - w_rbin_sync;
        // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal
        w_full_pattern = {~rgray_sync[AW:AW-1], rgray_sync[AW-2:0]};
        w_full_next    = (w_wgray_next == w_full_pattern);
    end

    // Pointer and status flag registers
    always_ff @(posedge wclk or negedge RST) begin
        if (!RST) begin
            r_wbin         <= {(AW+1){1'b0}};
            r_wgray        <= {(AW+1){1'b0}};
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wlevel       <= {(AW+1){1'b0}};
        end else begin
            r_wbin         <= w_wbin_next;
            r_wgray        <= w_wgray_next;
            r_wfull        <= w_full_next;
            r_walmost_full <= (w_level_next >= AFULL_L);
            r_wlevel       <= w_level_next;
        end
    end

    // Sticky overflow: a dropped write beats a simultaneous clear
    always_ff @(posedge wclk or negedge RST) begin
        if (!RST) begin
            r_wovf <= 1'b0;
        end else if (winc && r_wfull) begin
            r_wovf <= 1'b1;
        end else if (wovf_clr) begin
            r_wovf <= 1'b0;
        end else begin
            r_wovf <= r_wovf;
        end
    end

    generate
        if (RESET_MEM) begin : g_mem_rst
            // Storage array cleared on reset
            always_ff @(posedge wclk or negedge RST) begin
                if (!RST) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        r_mem[i] <= {DATA_WIDTH{1'b0}};
                    end
                end else if (w_wen) begin
                    r_mem[r_wbin[AW-1:0]] <= wdata;
                end
            end
        end else begin : g_mem_norst
            // Storage array without reset
            always_ff @(posedge wclk) begin
                if (w_wen) begin
                    r_mem[r_wbin[AW-1:0]] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata        = r_mem[raddr];
    assign wgray        = r_wgray;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wlevel       = r_wlevel;
    assign wovf         = r_wovf;

endmodule
